uart_rx_packet_parser: RTL and testbench

- Sits directly downstream of the UART receiver. Consumes its one-cycle byte strobe and byte, and frames the byte stream into packets of the form SYNC(0xA5), LEN, LEN payload bytes, CHK.
- Buffers the payload and checks the checksum.
- Replays good packets on a valid/ready byte stream with a last marker.
- Drops bad or stalled frames and pulses an error flag for each.

---
 rtl/uart_pkt_pkg.sv | 20 ++
 rtl/uart_pkt_buf.sv | 26 ++
 rtl/uart_rx_packet_parser.sv | 226 ++++++++++++++++++++++
 tb/tb_uart_rx_packet_parser.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkt_pkg.sv
// Shared constants and state encoding for the UART packet parser.
package uart_pkt_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam int         MIN_LEN   = 1;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        PAYLOAD,
        CHK,
        SEND
    } state_t;

    // Address width for a register buffer of the given depth, never narrower than 1.
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/uart_pkt_buf.sv
// Payload buffer: DEPTH x 8 registers, one synchronous write port, one combinational read port.
// Latency: write visible the cycle after i_Wr_En; read is same-cycle.
// Backpressure: none, the parser owns both ports.
module uart_pkt_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          i_Clock,
    input  logic          i_Wr_En,
    input  logic [AW-1:0] i_Wr_Addr,
    input  logic [7:0]    i_Wr_Data,
    input  logic [AW-1:0] i_Rd_Addr,
    output logic [7:0]    o_Rd_Data
);

    logic [7:0] r_mem [DEPTH];

    always_ff @(posedge i_Clock) begin
        if (i_Wr_En) begin
            r_mem[i_Wr_Addr] <= i_Wr_Data;
        end
    end

    assign o_Rd_Data = r_mem[i_Rd_Addr];

endmodule

// File: rtl/uart_rx_packet_parser.sv
// Frames UART bytes as A5,LEN,payload,CHK; replays good payloads; optional stats via UART_PKT_STATS_EN.
// Latency: o_Valid rises the cycle after the CHK byte strobe; error pulses one cycle after the cause.
// Backpressure: output held while o_Valid && !i_Ready; bytes arriving during replay are dropped (o_Overrun).
module uart_rx_packet_parser
    import uart_pkt_pkg::*;
#(
    parameter int MAX_LEN      = 16,
    parameter int TIMEOUT_CLKS = 2170
) (
    input  logic        i_Clock,
    input  logic        i_Rst,
    input  logic        i_RX_DV,
    input  logic [7:0]  i_RX_Byte,
    output logic        o_Valid,
    input  logic        i_Ready,
    output logic [7:0]  o_Data,
    output logic        o_Last,
    output logic [7:0]  o_Len,
    output logic        o_Err_Chk,
    output logic        o_Err_Len,
    output logic        o_Err_Timeout,
    output logic        o_Overrun
`ifdef UART_PKT_STATS_EN
    ,
    output logic [15:0] o_Good_Cnt,
    output logic [15:0] o_Err_Cnt
`endif
);

    localparam int IW = $clog2(MAX_LEN + 1);
    localparam int AW = addr_w(MAX_LEN);
    localparam int TW = $clog2(TIMEOUT_CLKS + 1);

    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [7:0]    MIN_LEN_B = 8'(MIN_LEN);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CLKS - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [7:0]    r_len;
    logic [7:0]    w_len_nxt;
    logic [7:0]    r_sum;
    logic [7:0]    w_sum_nxt;
    logic [IW-1:0] r_wr_idx;
    logic [IW-1:0] w_wr_idx_nxt;
    logic [IW-1:0] r_rd_idx;
    logic [IW-1:0] w_rd_idx_nxt;
    logic [TW-1:0] r_tmo_cnt;
    logic [TW-1:0] w_tmo_cnt_nxt;

    logic          r_err_chk;
    logic          r_err_len;
    logic          r_err_tmo;
    logic          r_overrun;
    logic          w_err_chk;
    logic          w_err_len;
    logic          w_err_tmo;
    logic          w_overrun;

    logic          w_buf_wr;
    logic [7:0]    w_rd_data;
    logic [7:0]    w_chk_sum;
    logic          w_in_frame;
    logic          w_tmo_hit;
    logic          w_last;
    logic          w_xfer;

    uart_pkt_buf #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_buf (
        .i_Clock   (i_Clock),
        .i_Wr_En   (w_buf_wr),
        .i_Wr_Addr (r_wr_idx[AW-1:0]),
        .i_Wr_Data (i_RX_Byte),
        .i_Rd_Addr (r_rd_idx[AW-1:0]),
        .o_Rd_Data (w_rd_data)
    );

    assign w_in_frame = (r_state == LEN) || (r_state == PAYLOAD) || (r_state == CHK);
    // A strobe in the same cycle as expiry wins over the timeout.
    assign w_tmo_hit  = w_in_frame && !i_RX_DV && (r_tmo_cnt == TMO_LAST);
    assign w_chk_sum  = r_sum + i_RX_Byte;
    assign w_last     = (8'(r_rd_idx) == (r_len - 8'd1));
    assign w_xfer     = (r_state == SEND) && i_Ready;

    always_comb begin
        w_state_nxt   = r_state;
        w_len_nxt     = r_len;
        w_sum_nxt     = r_sum;
        w_wr_idx_nxt  = r_wr_idx;
        w_rd_idx_nxt  = r_rd_idx;
        w_err_chk     = 1'b0;
        w_err_len     = 1'b0;
        w_err_tmo     = 1'b0;
        w_overrun     = 1'b0;
        w_buf_wr      = 1'b0;
        w_tmo_cnt_nxt = (w_in_frame && !i_RX_DV && !w_tmo_hit) ? r_tmo_cnt + 1'b1 : '0;

        case (r_state)
            IDLE: begin
                if (i_RX_DV && (i_RX_Byte == SYNC_BYTE)) begin
                    w_state_nxt = LEN;
                end
            end
            LEN: begin
                if (i_RX_DV) begin
                    if ((i_RX_Byte < MIN_LEN_B) || (i_RX_Byte > MAX_LEN_B)) begin
                        w_err_len   = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_len_nxt    = i_RX_Byte;
                        w_sum_nxt    = i_RX_Byte;
                        w_wr_idx_nxt = '0;
                        w_state_nxt  = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (i_RX_DV) begin
                    w_buf_wr     = 1'b1;
                    w_sum_nxt    = w_chk_sum;
                    w_wr_idx_nxt = r_wr_idx + 1'b1;
                    if (8'(r_wr_idx) == (r_len - 8'd1)) begin
                        w_state_nxt = CHK;
                    end
                end
            end
            CHK: begin
                if (i_RX_DV) begin
                    if (w_chk_sum == 8'h00) begin
                        w_rd_idx_nxt = '0;
                        w_state_nxt  = SEND;
                    end else begin
                        w_err_chk   = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
            end
            SEND: begin
                // Incoming bytes are never parsed while the buffer is being replayed.
                w_overrun = i_RX_DV;
                if (w_xfer) begin
                    w_rd_idx_nxt = r_rd_idx + 1'b1;
                    if (w_last) begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        if (w_tmo_hit) begin
            w_err_tmo   = 1'b1;
            w_state_nxt = IDLE;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Rst) begin
            r_state   <= IDLE;
            r_len     <= 8'h00;
            r_sum     <= 8'h00;
            r_wr_idx  <= '0;
            r_rd_idx  <= '0;
            r_tmo_cnt <= '0;
            r_err_chk <= 1'b0;
            r_err_len <= 1'b0;
            r_err_tmo <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_len     <= w_len_nxt;
            r_sum     <= w_sum_nxt;
            r_wr_idx  <= w_wr_idx_nxt;
            r_rd_idx  <= w_rd_idx_nxt;
            r_tmo_cnt <= w_tmo_cnt_nxt;
            r_err_chk <= w_err_chk;
            r_err_len <= w_err_len;
            r_err_tmo <= w_err_tmo;
            r_overrun <= w_overrun;
        end
    end

    // Outputs are forced to zero outside SEND so idle reads of the buffer never leak.
    assign o_Valid       = (r_state == SEND);
    assign o_Data        = o_Valid ? w_rd_data : 8'h00;
    assign o_Len         = o_Valid ? r_len : 8'h00;
    assign o_Last        = o_Valid && w_last;
    assign o_Err_Chk     = r_err_chk;
    assign o_Err_Len     = r_err_len;
    assign o_Err_Timeout = r_err_tmo;
    assign o_Overrun     = r_overrun;

`ifdef UART_PKT_STATS_EN
    logic [15:0] r_good_cnt;
    logic [15:0] r_err_cnt;
    logic        w_good_evt;
    logic        w_err_evt;

    assign w_good_evt = (r_state == CHK) && (w_state_nxt == SEND);
    assign w_err_evt  = r_err_chk || r_err_len || r_err_tmo || r_overrun;

    always_ff @(posedge i_Clock) begin
        if (i_Rst) begin
            r_good_cnt <= 16'h0000;
            r_err_cnt  <= 16'h0000;
        end else begin
            if (w_good_evt && (r_good_cnt != 16'hFFFF)) begin
                r_good_cnt <= r_good_cnt + 16'd1;
            end
            if (w_err_evt && (r_err_cnt != 16'hFFFF)) begin
                r_err_cnt <= r_err_cnt + 16'd1;
            end
        end
    end

    assign o_Good_Cnt = r_good_cnt;
    assign o_Err_Cnt  = r_err_cnt;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_uart_rx_packet_parser.sv
// Scoreboard bench: a frame-level reference model queues expected beats and error events;
// a negedge monitor pops and compares whatever the parser presents.
module tb_uart_rx_packet_parser;

    localparam int MAX_LEN = 16;
    localparam int TMO     = 40;

    localparam int EV_CHK = 1;
    localparam int EV_LEN = 2;
    localparam int EV_TMO = 3;
    localparam int EV_OVR = 4;

    logic       i_Clock   = 1'b0;
    logic       i_Rst     = 1'b1;
    logic       i_RX_DV   = 1'b0;
    logic [7:0] i_RX_Byte = 8'h00;
    logic       i_Ready   = 1'b0;
    logic       o_Valid;
    logic [7:0] o_Data;
    logic       o_Last;
    logic [7:0] o_Len;
    logic       o_Err_Chk;
    logic       o_Err_Len;
    logic       o_Err_Timeout;
    logic       o_Overrun;

    always #5 i_Clock = ~i_Clock;

    uart_rx_packet_parser #(
        .MAX_LEN      (MAX_LEN),
        .TIMEOUT_CLKS (TMO)
    ) dut (
        .i_Clock       (i_Clock),
        .i_Rst         (i_Rst),
        .i_RX_DV       (i_RX_DV),
        .i_RX_Byte     (i_RX_Byte),
        .o_Valid       (o_Valid),
        .i_Ready       (i_Ready),
        .o_Data        (o_Data),
        .o_Last        (o_Last),
        .o_Len         (o_Len),
        .o_Err_Chk     (o_Err_Chk),
        .o_Err_Len     (o_Err_Len),
        .o_Err_Timeout (o_Err_Timeout),
        .o_Overrun     (o_Overrun)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic [7:0] len;
    } beat_t;

    beat_t      exp_q[$];
    int         ev_q[$];
    int         n_cmp     = 0;
    int         n_bad     = 0;
    int         cyc       = 0;
    int         rdy_mode  = 0;
    logic [7:0] frame_q[$];
    bit         in_frame  = 1'b0;
    int         last_dv   = 0;
    int         send_left = 0;
    logic [7:0] tx_q[$];
    beat_t      mon_e;
    beat_t      prev_o;
    bit         prev_stall = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: works on whole frames and byte timestamps rather than per-cycle state.
    task automatic model_cycle(input bit dv, input logic [7:0] b);
        int    l;
        int    s;
        beat_t o;
        if (dv) begin
            if (send_left > 0) begin
                ev_q.push_back(EV_OVR);
            end else if (!in_frame) begin
                if (b == 8'hA5) begin
                    in_frame = 1'b1;
                    frame_q.delete();
                    last_dv  = cyc;
                end
            end else begin
                frame_q.push_back(b);
                last_dv = cyc;
                l = int'(frame_q[0]);
                if (frame_q.size() == 1 && (l == 0 || l > MAX_LEN)) begin
                    ev_q.push_back(EV_LEN);
                    in_frame = 1'b0;
                end else if (frame_q.size() == l + 2) begin
                    s = 0;
                    foreach (frame_q[i]) s += int'(frame_q[i]);
                    if (s % 256 == 0) begin
                        for (int i = 1; i <= l; i++) begin
                            o.data = frame_q[i];
                            o.last = (i == l);
                            o.len  = 8'(l);
                            exp_q.push_back(o);
                        end
                        send_left = l;
                    end else begin
                        ev_q.push_back(EV_CHK);
                    end
                    in_frame = 1'b0;
                end
            end
        end else if (in_frame && (cyc - last_dv == TMO)) begin
            ev_q.push_back(EV_TMO);
            in_frame = 1'b0;
        end
    endtask

    task automatic tick(input bit dv, input logic [7:0] b);
        @(posedge i_Clock);
        #1;
        i_Rst     = 1'b0;
        i_RX_DV   = dv;
        i_RX_Byte = dv ? b : 8'($urandom);
        case (rdy_mode)
            0:       i_Ready = 1'b1;
            1:       i_Ready = ~i_Ready;
            2:       i_Ready = 1'($urandom);
            default: i_Ready = 1'b0;
        endcase
        cyc++;
        model_cycle(dv, b);
    endtask

    task automatic do_reset();
        @(posedge i_Clock);
        #1;
        i_Rst   = 1'b1;
        i_RX_DV = 1'b0;
        i_Ready = 1'b0;
        cyc++;
        in_frame  = 1'b0;
        send_left = 0;
        exp_q.delete();
        frame_q.delete();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(1'b0, 8'h00);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        for (int k = 1; k < gap; k++) tick(1'b0, 8'h00);
        tick(1'b1, b);
    endtask

    task automatic send_tx(input int gap);
        foreach (tx_q[i]) send_byte(tx_q[i], gap);
        tx_q.delete();
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (send_left > 0 && n < 2000) begin
            tick(1'b0, 8'h00);
            n++;
        end
        n_cmp++;
        if (send_left > 0) begin
            n_bad++;
            $display("FAIL drain: %0d beats still pending after %0d cycles, want 0", send_left, n);
        end
        idle(2);
    endtask

    task automatic ev_pop(input int code);
        if (ev_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL pulse: got unexpected event %0d, want none (cycle %0d)", code, cyc);
        end else begin
            check("pulse", 32'(code), 32'(ev_q.pop_front()));
        end
    endtask

    always @(negedge i_Clock) begin
        if (o_Valid && i_Ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL beat: got data 0x%0h with no beat expected (cycle %0d)", o_Data, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("beat {data,last,len}", 32'({o_Data, o_Last, o_Len}), 32'(mon_e));
                if (send_left > 0) send_left--;
            end
        end
        if (prev_stall && o_Valid) begin
            check("stall hold", 32'({o_Data, o_Last, o_Len}), 32'(prev_o));
        end
        prev_stall = o_Valid && !i_Ready;
        prev_o     = {o_Data, o_Last, o_Len};
        if (o_Err_Chk)     ev_pop(EV_CHK);
        if (o_Err_Len)     ev_pop(EV_LEN);
        if (o_Err_Timeout) ev_pop(EV_TMO);
        if (o_Overrun)     ev_pop(EV_OVR);
    end

    task automatic check_zero_outputs(input string tag);
        @(negedge i_Clock);
        check({tag, " o_Valid"}, 32'(o_Valid), 0);
        check({tag, " o_Data"},  32'(o_Data),  0);
        check({tag, " o_Last"},  32'(o_Last),  0);
        check({tag, " o_Len"},   32'(o_Len),   0);
        check({tag, " errors"},  32'({o_Err_Chk, o_Err_Len, o_Err_Timeout, o_Overrun}), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, want finish before 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        int         l;
        int         s;
        logic [7:0] b;
        logic [7:0] chk;

        rdy_mode = 0;
        do_reset();
        do_reset();
        tick(1'b0, 8'h00);
        check_zero_outputs("reset");

        // Good packet with free-flowing output, plus first-beat latency.
        tx_q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33};
        send_tx(1);
        tick(1'b1, 8'h97);
        @(negedge i_Clock);
        check("valid on chk cycle", 32'(o_Valid), 0);
        tick(1'b0, 8'h00);
        @(negedge i_Clock);
        check("valid one cycle after chk", 32'(o_Valid), 1);
        check("o_Len while valid", 32'(o_Len), 3);
        wait_drain();
        check("valid after last", 32'(o_Valid), 0);

        // Same packet under alternating ready.
        rdy_mode = 1;
        tx_q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
        send_tx(1);
        wait_drain();

        // Bad checksum, then two single-byte frames: 01+7F+81 wraps to 01, 01+7F+80 wraps to 00.
        rdy_mode = 0;
        tx_q = '{8'hA5, 8'h02, 8'h01, 8'h02, 8'h00,
                 8'hA5, 8'h01, 8'h7F, 8'h81,
                 8'hA5, 8'h01, 8'h7F, 8'h80};
        send_tx(1);
        wait_drain();

        // Length errors at both ends.
        tx_q = '{8'hA5, 8'h00, 8'hA5, 8'h11};
        send_tx(2);
        idle(3);

        // Timeout inside payload, then trailing bytes are only hunted.
        tx_q = '{8'hA5, 8'h02, 8'h10};
        send_tx(1);
        idle(TMO + 5);
        tx_q = '{8'h20, 8'hCE};
        send_tx(1);
        idle(3);

        // Gaps of exactly the timeout length must not abort the frame.
        tx_q = '{8'hA5, 8'h01, 8'h55, 8'hAA};
        send_tx(TMO);
        wait_drain();

        // Full-length packet.
        s = MAX_LEN;
        tx_q = '{8'hA5, 8'(MAX_LEN)};
        for (int i = 0; i < MAX_LEN; i++) begin
            b = 8'(i * 13 + 1);
            tx_q.push_back(b);
            s += int'(b);
        end
        tx_q.push_back(8'((256 - (s % 256)) % 256));
        send_tx(1);
        wait_drain();

        // Overrun while stalled in replay, then reset mid-replay.
        rdy_mode = 3;
        tx_q = '{8'hA5, 8'h02, 8'h33, 8'h44, 8'h87};
        send_tx(1);
        idle(2);
        send_byte(8'h55, 1);
        send_byte(8'hA5, 2);
        do_reset();
        tick(1'b0, 8'h00);
        check_zero_outputs("post-reset");

        rdy_mode = 0;
        tx_q = '{8'hA5, 8'h01, 8'h42, 8'hBD};
        send_tx(1);
        wait_drain();

        // Randomized traffic.
        for (int f = 0; f < 60; f++) begin
            rdy_mode = $urandom_range(0, 2);
            if ($urandom_range(0, 9) != 0) wait_drain();
            if ($urandom_range(0, 3) == 0) send_byte(8'($urandom), $urandom_range(1, 3));
            if ($urandom_range(0, 7) == 0) l = $urandom_range(MAX_LEN + 1, 255);
            else                           l = $urandom_range(0, MAX_LEN + 1);
            send_byte(8'hA5, $urandom_range(1, 3));
            send_byte(8'(l), ($urandom_range(0, 19) == 0) ? TMO + $urandom_range(0, 2) : $urandom_range(1, 3));
            if (l == 0 || l > MAX_LEN) begin
                send_byte(8'($urandom), 1);
                send_byte(8'($urandom), 1);
            end else begin
                s = l;
                for (int i = 0; i < l; i++) begin
                    b = 8'($urandom);
                    s += int'(b);
                    send_byte(b, ($urandom_range(0, 19) == 0) ? TMO + $urandom_range(0, 2) : $urandom_range(1, 3));
                end
                chk = 8'((256 - (s % 256)) % 256);
                if ($urandom_range(0, 3) == 0) chk = chk + 8'($urandom_range(1, 255));
                send_byte(chk, $urandom_range(1, 3));
            end
        end

        rdy_mode = 0;
        wait_drain();
        idle(TMO + 5);
        check("beats left over", 32'(exp_q.size()), 0);
        check("events left over", 32'(ev_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
